// File: rtl/prog_loader_if.sv
// Byte-stream input handshake and imem write port of the boot program loader.
// master = stream source / imem side, slave = the loader.
interface prog_loader_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          wr_en;
    logic [AW-1:0] wr_ad;
    logic [DW-1:0] wr_data;

    modport master (
        output in_valid, in_data,
        input  in_ready, wr_en, wr_ad, wr_data
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, wr_en, wr_ad, wr_data
    );
endinterface

// File: rtl/prog_loader.sv
// Boot program loader: length header + program bytes into imem, then releases cpu reset.
// Optional PROG_LOADER_CHECKSUM_EN adds a trailing checksum byte and an error state.
module prog_loader #(
    parameter int AW          = 8,
    parameter int DW          = 8,
    parameter int HOLD_CYCLES = 2
) (
    input  logic           clk,
    input  logic           reset,
    prog_loader_if.slave   bus,
    input  logic           reload,
    output logic           cpu_reset,
    output logic           done,
    output logic           err
);
    localparam int HW = 4;
    localparam logic [AW:0] REM_FULL = (AW+1)'(1) << AW;

    typedef enum logic [2:0] {
        S_HDR,
        S_DATA,
        S_HOLD,
        S_RUN
`ifdef PROG_LOADER_CHECKSUM_EN
        , S_CSUM,
        S_ERR
`endif
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [AW:0]   rem_q, rem_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          wr_en_q, wr_en_d;
    logic [AW-1:0] wr_ad_q, wr_ad_d;
    logic [DW-1:0] wr_data_q, wr_data_d;
    logic          cpu_reset_q, cpu_reset_d;
    logic          done_q, done_d;
    logic          in_ready;
    logic          xfer;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic          err_q, err_d;
    logic [DW-1:0] sum_q, sum_d;
    logic [DW-1:0] sum_chk;
`endif

    always_comb begin
        in_ready = 1'b0;
        case (state_q)
            S_HDR, S_DATA: in_ready = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
            S_CSUM:        in_ready = 1'b1;
`endif
            default:       in_ready = 1'b0;
        endcase
    end

    assign xfer = bus.in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        rem_d       = rem_q;
        hold_d      = hold_q;
        wr_en_d     = 1'b0;
        wr_ad_d     = wr_ad_q;
        wr_data_d   = wr_data_q;
        cpu_reset_d = cpu_reset_q;
        done_d      = done_q;
`ifdef PROG_LOADER_CHECKSUM_EN
        err_d       = err_q;
        sum_d       = sum_q;
        sum_chk     = sum_q + bus.in_data;
`endif
        case (state_q)
            S_HDR: begin
                if (xfer) begin
                    // A zero header encodes a full-depth program.
                    rem_d   = (bus.in_data == '0) ? REM_FULL : (AW+1)'(bus.in_data);
                    ptr_d   = '0;
                    state_d = S_DATA;
`ifdef PROG_LOADER_CHECKSUM_EN
                    sum_d   = bus.in_data;
`endif
                end
            end
            S_DATA: begin
                if (xfer) begin
                    wr_en_d   = 1'b1;
                    wr_ad_d   = ptr_q;
                    wr_data_d = bus.in_data;
                    ptr_d     = ptr_q + AW'(1);
                    rem_d     = rem_q - (AW+1)'(1);
`ifdef PROG_LOADER_CHECKSUM_EN
                    sum_d     = sum_chk;
                    if (rem_q == (AW+1)'(1)) begin
                        state_d = S_CSUM;
                    end
`else
                    if (rem_q == (AW+1)'(1)) begin
                        state_d = S_HOLD;
                        hold_d  = HW'(HOLD_CYCLES);
                    end
`endif
                end
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (xfer) begin
                    if (sum_chk == '0) begin
                        state_d = S_HOLD;
                        hold_d  = HW'(HOLD_CYCLES);
                    end else begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end
                end
            end
            S_ERR: begin
                if (reload) begin
                    state_d     = S_HDR;
                    err_d       = 1'b0;
                    cpu_reset_d = 1'b1;
                    done_d      = 1'b0;
                end
            end
`endif
            S_HOLD: begin
                // Guarantees the final imem write lands before the cpu leaves reset.
                if (hold_q == '0) begin
                    state_d     = S_RUN;
                    cpu_reset_d = 1'b0;
                    done_d      = 1'b1;
                end else begin
                    hold_d = hold_q - HW'(1);
                end
            end
            S_RUN: begin
                if (reload) begin
                    state_d     = S_HDR;
                    cpu_reset_d = 1'b1;
                    done_d      = 1'b0;
                end
            end
            default: state_d = S_HDR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_HDR;
            ptr_q       <= '0;
            rem_q       <= '0;
            hold_q      <= '0;
            wr_en_q     <= 1'b0;
            wr_ad_q     <= '0;
            wr_data_q   <= '0;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            err_q       <= 1'b0;
            sum_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            rem_q       <= rem_d;
            hold_q      <= hold_d;
            wr_en_q     <= wr_en_d;
            wr_ad_q     <= wr_ad_d;
            wr_data_q   <= wr_data_d;
            cpu_reset_q <= cpu_reset_d;
            done_q      <= done_d;
`ifdef PROG_LOADER_CHECKSUM_EN
            err_q       <= err_d;
            sum_q       <= sum_d;
`endif
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_ad    = wr_ad_q;
    assign bus.wr_data  = wr_data_q;
    assign cpu_reset    = cpu_reset_q;
    assign done         = done_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    assign err          = err_q;
`else
    assign err          = 1'b0;
`endif
endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: per-cycle vector table plus hand sequences
// for the 256-byte load and (when PROG_LOADER_CHECKSUM_EN is defined) checksum handling.
module tb_prog_loader;
`ifdef PROG_LOADER_CHECKSUM_EN
    localparam bit CS = 1'b1;
`else
    localparam bit CS = 1'b0;
`endif

    logic clk;
    logic reset;
    logic reload;
    logic cpu_reset;
    logic done;
    logic err;

    int total;
    int bad;

    prog_loader_if #(.AW(8), .DW(8)) bus ();

    prog_loader #(.AW(8), .DW(8), .HOLD_CYCLES(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .reload    (reload),
        .cpu_reset (cpu_reset),
        .done      (done),
        .err       (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       rst;
        logic       v;
        logic [7:0] d;
        logic       rl;
        logic       e_wr;
        logic [7:0] e_ad;
        logic [7:0] e_dat;
        logic       e_cpu;
        logic       e_done;
        logic       e_rdy;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic rst, input logic v, input logic [7:0] d, input logic rl,
                       input logic wr, input logic [7:0] ad, input logic [7:0] dat,
                       input logic cpu, input logic dn, input logic rdy);
        vec_t r;
        r.rst = rst; r.v = v; r.d = d; r.rl = rl;
        r.e_wr = wr; r.e_ad = ad; r.e_dat = dat;
        r.e_cpu = cpu; r.e_done = dn; r.e_rdy = rdy;
        vq.push_back(r);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        tick();
        bus.in_valid = 1'b0;
        $display("byte %02h sent: wr_en=%0d cpu_reset=%0d err=%0d", b, bus.wr_en, cpu_reset, err);
    endtask

    task automatic pulse_reload;
        reload = 1'b1;
        tick();
        reload = 1'b0;
        $display("reload: cpu_reset=%0d done=%0d in_ready=%0d", cpu_reset, done, bus.in_ready);
    endtask

    // One byte of the load sequence: 'last' decides what in_ready looks like afterwards.
    task automatic add_byte(input logic [7:0] b, input logic [7:0] ad, input bit last);
        add(0, 1, b, 0, 1, ad, b, 1, 0, last ? CS : 1'b1);
    endtask

    // Optional checksum byte, then the HOLD_CYCLES=2 release tail.
    task automatic add_tail(input logic [7:0] csum);
        if (CS) add(0, 1, csum, 0, 0, 0, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    endtask

    initial begin
        logic [7:0] pat [3];
        int waited;
        total = 0;
        bad   = 0;
        reset = 1'b1;
        reload = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        pat[0] = 8'h11; pat[1] = 8'h22; pat[2] = 8'h33;

        // Reset, then header 3 + three back-to-back bytes.
        add(1, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        add(0, 1, 8'h03, 0, 0, 0, 0, 1, 0, 1);
        for (int k = 0; k < 3; k++) add_byte(pat[k], 8'(k), k == 2);
        add_tail(8'h97);
        // Bytes offered in RUN are ignored; reload re-arms.
        add(0, 1, 8'h55, 0, 0, 0, 0, 0, 1, 0);
        add(0, 1, 8'h66, 0, 0, 0, 0, 0, 1, 0);
        add(0, 0, 0, 1, 0, 0, 0, 1, 0, 1);
        // Same stream with 4-cycle gaps.
        add(0, 1, 8'h03, 0, 0, 0, 0, 1, 0, 1);
        for (int k = 0; k < 3; k++) begin
            for (int g = 0; g < 4; g++) add(0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
            add_byte(pat[k], 8'(k), k == 2);
        end
        add_tail(8'h97);
        // Reset after 2 of 5 bytes, with a byte offered in the reset cycle.
        add(0, 0, 0, 1, 0, 0, 0, 1, 0, 1);
        add(0, 1, 8'h05, 0, 0, 0, 0, 1, 0, 1);
        add_byte(8'h01, 8'h00, 0);
        add_byte(8'h02, 8'h01, 0);
        add(1, 1, 8'h77, 0, 0, 0, 0, 1, 0, 1);
        add(0, 1, 8'h01, 0, 0, 0, 0, 1, 0, 1);
        add_byte(8'hAA, 8'h00, 1);
        add_tail(8'h55);

        foreach (vq[i]) begin
            reset        = vq[i].rst;
            bus.in_valid = vq[i].v;
            bus.in_data  = vq[i].d;
            reload       = vq[i].rl;
            tick();
            $display("vec %0d: v=%0d d=%02h rl=%0d rst=%0d -> wr_en=%0d ad=%02h data=%02h cpu_reset=%0d done=%0d in_ready=%0d",
                     i, vq[i].v, vq[i].d, vq[i].rl, vq[i].rst, bus.wr_en, bus.wr_ad, bus.wr_data,
                     cpu_reset, done, bus.in_ready);
            chk($sformatf("vec%0d wr_en", i), int'(bus.wr_en), int'(vq[i].e_wr));
            if (vq[i].e_wr) begin
                chk($sformatf("vec%0d wr_ad", i), int'(bus.wr_ad), int'(vq[i].e_ad));
                chk($sformatf("vec%0d wr_data", i), int'(bus.wr_data), int'(vq[i].e_dat));
            end
            chk($sformatf("vec%0d cpu_reset", i), int'(cpu_reset), int'(vq[i].e_cpu));
            chk($sformatf("vec%0d done", i), int'(done), int'(vq[i].e_done));
            chk($sformatf("vec%0d in_ready", i), int'(bus.in_ready), int'(vq[i].e_rdy));
            chk($sformatf("vec%0d err", i), int'(err), 0);
        end
        reset = 1'b0;
        reload = 1'b0;
        bus.in_valid = 1'b0;

        // Header 0 => 256 bytes; address must reach 0xFF without wrapping early.
        pulse_reload();
        chk("full reload in_ready", int'(bus.in_ready), 1);
        send_byte(8'h00);
        for (int i = 0; i < 256; i++) begin
            send_byte(8'(i));
            chk($sformatf("full wr_en %0d", i), int'(bus.wr_en), 1);
            chk($sformatf("full wr_ad %0d", i), int'(bus.wr_ad), i);
            chk($sformatf("full wr_data %0d", i), int'(bus.wr_data), i);
        end
        if (CS) send_byte(8'h80);
        waited = 0;
        while (!done && waited < 10) begin
            tick();
            chk("full no extra write", int'(bus.wr_en), 0);
            waited++;
        end
        chk("full done reached", int'(done), 1);
        chk("full cpu_reset released", int'(cpu_reset), 0);
        chk("full last wr_ad", int'(bus.wr_ad), 8'hFF);

`ifdef PROG_LOADER_CHECKSUM_EN
        // Good checksum: 02+10+20+CE = 0x100.
        pulse_reload();
        send_byte(8'h02);
        send_byte(8'h10);
        send_byte(8'h20);
        send_byte(8'hCE);
        for (int c = 0; c < 3; c++) tick();
        chk("csum good done", int'(done), 1);
        chk("csum good err", int'(err), 0);
        chk("csum good cpu_reset", int'(cpu_reset), 0);
        // Bad checksum parks in ERR.
        pulse_reload();
        send_byte(8'h02);
        send_byte(8'h10);
        send_byte(8'h20);
        send_byte(8'hCF);
        chk("csum bad err", int'(err), 1);
        chk("csum bad cpu_reset", int'(cpu_reset), 1);
        chk("csum bad in_ready", int'(bus.in_ready), 0);
        chk("csum bad done", int'(done), 0);
        for (int c = 0; c < 5; c++) tick();
        chk("csum bad err held", int'(err), 1);
        chk("csum bad cpu_reset held", int'(cpu_reset), 1);
        pulse_reload();
        chk("csum reload err", int'(err), 0);
        chk("csum reload in_ready", int'(bus.in_ready), 1);
        chk("csum reload cpu_reset", int'(cpu_reset), 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
